// File: rtl/key_note_encoder_if.sv
// Purpose : note-change event channel from the keyboard front end to the recorder.
// Latency : n/a (signal bundle only).
// Backpressure: the recorder holds off the producer by keeping note_ready low.
//   note_valid  producer -> consumer  event pending
//   note_evt    producer -> consumer  5-bit note code carried by the event
//   note_ready  consumer -> producer  event accepted when high with note_valid
interface key_note_encoder_if;
    logic       note_valid;
    logic [4:0] note_evt;
    logic       note_ready;

    modport master (output note_valid, output note_evt, input note_ready);
    modport slave  (input note_valid, input note_evt, output note_ready);
endinterface

// File: rtl/key_note_encoder.sv
// Purpose : debounces note switches and octave buttons, encodes a 5-bit note code
//           (0 rest, 1-7 low, 8-14 mid, 15-21 high) and emits note-change events.
// Latency : an input held steady from cycle t reaches o_note_cur at t + DEBOUNCE_CYCLES + 3.
// Backpressure: one pending event; a new change while unaccepted overwrites it (latest wins)
//               and sets the sticky o_overrun flag.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   i_key_sw[7:1]     note switches, bit7 = degree 1 ... bit1 = degree 7 (bit0 unused)
//   i_oct_up_btn      raw octave-up button
//   i_oct_dn_btn      raw octave-down button
//   o_note_cur        current note code 0..21
//   o_octave          current octave 0..2
//   o_overrun         sticky: an unaccepted event was overwritten
//   o_multi_err       more than one note switch down (MULTI_KEY_ERR_EN only, else 0)
//   evt_if            note_valid / note_evt / note_ready event channel (master side)
// Build option: define MULTI_KEY_ERR_EN to force rest and flag o_multi_err when several
//               keys are down; otherwise the highest key bit wins.
module key_note_encoder #(
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int OCT_RESET       = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                i_key_sw,
    input  logic                      i_oct_up_btn,
    input  logic                      i_oct_dn_btn,
    output logic [4:0]                o_note_cur,
    output logic [1:0]                o_octave,
    output logic                      o_overrun,
    output logic                      o_multi_err,
    key_note_encoder_if.master        evt_if
);

    localparam int             CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0]     OCT_RST = 2'(OCT_RESET);

    typedef enum logic {S_IDLE, S_PEND} state_t;

    // vector layout: [8:2] = key_sw[7:1], [1] = octave up, [0] = octave down
    logic [8:0]    w_raw;
    logic [8:0]    r_sync1;
    logic [8:0]    r_sync2;
    logic [8:0]    r_cand;
    logic [8:0]    r_stable;
    logic [8:0]    r_stable_d;
    logic [CW-1:0] r_cnt;

    logic [1:0]    r_octave;
    logic          w_up_rise;
    logic          w_dn_rise;

    logic [6:0]    w_keys;
    logic [2:0]    w_degree;
    logic          w_multi;
    logic [4:0]    w_note_nxt;
    logic [4:0]    r_note_cur;
    logic          w_chg;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_evt_load;
    logic          w_ovr_set;
    logic [4:0]    r_note_evt;
    logic          r_overrun;

    logic          w_unused;

    assign w_raw    = {i_key_sw[7:1], i_oct_up_btn, i_oct_dn_btn};
    assign w_unused = i_key_sw[0];

    // Synchronizer plus one shared debounce counter for the whole vector.
    // The candidate is copied once the counter has seen it unchanged long enough;
    // the copy is unconditional on that cycle so a value held exactly
    // DEBOUNCE_CYCLES cycles is accepted even if the input moves right after.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_cand     <= '0;
            r_stable   <= '0;
            r_stable_d <= '0;
            r_cnt      <= '0;
        end else begin
            r_sync1    <= w_raw;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            if (r_sync2 != r_cand) begin
                r_cand <= r_sync2;
                r_cnt  <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_cnt == CNT_MAX) begin
                r_stable <= r_cand;
            end
        end
    end

    assign w_up_rise = r_stable[1] & ~r_stable_d[1];
    assign w_dn_rise = r_stable[0] & ~r_stable_d[0];

    // Simultaneous up and down edges cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_octave <= OCT_RST;
        end else if (w_up_rise && !w_dn_rise && (r_octave != 2'd2)) begin
            r_octave <= r_octave + 2'd1;
        end else if (w_dn_rise && !w_up_rise && (r_octave != 2'd0)) begin
            r_octave <= r_octave - 2'd1;
        end
    end

    assign w_keys = r_stable[8:2];

    // Highest key bit has the lowest degree, so scanning upward lets it win.
    always_comb begin
        w_degree   = 3'd0;
        w_note_nxt = 5'd0;
        for (int i = 0; i < 7; i++) begin
            if (w_keys[i]) begin
                w_degree = 3'(7 - i);
            end
        end
`ifdef MULTI_KEY_ERR_EN
        w_multi = |(w_keys & (w_keys - 7'd1));
`else
        w_multi = 1'b0;
`endif
        if ((w_degree != 3'd0) && !w_multi) begin
            w_note_nxt = ({3'b000, r_octave} * 5'd7) + {2'b00, w_degree};
        end
    end

    assign w_chg = (w_note_nxt != r_note_cur);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_note_cur <= '0;
        end else begin
            r_note_cur <= w_note_nxt;
        end
    end

    // Event FSM: the event is raised on the same edge that note_cur takes the new code.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_evt_load  = 1'b0;
        w_ovr_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_chg) begin
                    w_evt_load  = 1'b1;
                    w_state_nxt = S_PEND;
                end
            end
            S_PEND: begin
                if (w_chg) begin
                    // with ready the old event is consumed, otherwise it is lost
                    w_evt_load = 1'b1;
                    w_ovr_set  = !evt_if.note_ready;
                end else if (evt_if.note_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_note_evt <= '0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_evt_load) begin
                r_note_evt <= w_note_nxt;
            end
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign o_note_cur        = r_note_cur;
    assign o_octave          = r_octave;
    assign o_overrun         = r_overrun;
    assign o_multi_err       = w_multi;
    assign evt_if.note_valid = (r_state == S_PEND);
    assign evt_if.note_evt   = r_note_evt;

endmodule
